// File: rtl/adc_spi_scheduler_if.sv
// adc_spi_scheduler_if: sample-in / frame-out bundle of the ADC-to-SPI scheduler.
// The master modport is the scheduler's view; the slave modport is the
// ADC + transmitter side that surrounds it.
interface adc_spi_scheduler_if #(
    parameter int ADC_WIDTH       = 8,
    parameter int FIFO_DEPTH_BITS = 2
);
    logic                       enable;
    logic                       sample_rdy;
    logic [ADC_WIDTH-1:0]       sample_data;
    logic                       tx_busy;
    logic                       tx_start;
    logic [ADC_WIDTH:0]         tx_data;
    logic [FIFO_DEPTH_BITS:0]   fifo_level;
    logic                       overflow;

    modport master (
        input  enable, sample_rdy, sample_data, tx_busy,
        output tx_start, tx_data, fifo_level, overflow
    );

    modport slave (
        output enable, sample_rdy, sample_data, tx_busy,
        input  tx_start, tx_data, fifo_level, overflow
    );
endinterface

// File: rtl/adc_spi_scheduler.sv
// adc_spi_scheduler: buffers ADC samples in a small FIFO and feeds them to the
// 9-bit SPI debug transmitter through a start/busy handshake, inserting a
// status frame (dropped-sample count) after every STATUS_PERIOD sample frames.
// Optional busy-rise watchdog: define ADC_SCHED_TIMEOUT_EN to enable it.
module adc_spi_scheduler #(
    parameter int ADC_WIDTH       = 8,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int STATUS_PERIOD   = 16
`ifdef ADC_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 15
`endif
) (
    input  logic                  clk,
    input  logic                  rstn,
    adc_spi_scheduler_if.master   bus
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0]   LVL_FULL = (FIFO_DEPTH_BITS+1)'(DEPTH);
    localparam logic [FIFO_DEPTH_BITS:0]   LVL_ONE  = (FIFO_DEPTH_BITS+1)'(1);
    localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE  = FIFO_DEPTH_BITS'(1);
    localparam logic [ADC_WIDTH-1:0]       DROP_MAX = '1;
    localparam logic [ADC_WIDTH-1:0]       DROP_ONE = ADC_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                     state_reg;
    state_t                     state_next;

    logic [ADC_WIDTH-1:0]       mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_reg;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr_reg;
    logic [FIFO_DEPTH_BITS:0]   level_reg;

    logic [ADC_WIDTH:0]         tx_data_reg;
    logic                       tx_start_reg;
    logic                       frame_is_sample_reg;
    logic [ADC_WIDTH-1:0]       drop_cnt_reg;
    logic                       overflow_reg;
    logic                       status_pend;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       sample_req;
    logic                       push;
    logic                       pop;
    logic                       drop;
    logic                       load_status;
    logic                       frame_done;
    logic                       overflow_set;

    assign fifo_full  = (level_reg == LVL_FULL);
    assign fifo_empty = (level_reg == '0);
    assign sample_req = bus.sample_rdy & bus.enable;
    // A full FIFO still accepts the sample if the head leaves in the same cycle.
    assign push       = sample_req & (~fifo_full | pop);
    assign drop       = sample_req & fifo_full & ~pop;

`ifdef ADC_SCHED_TIMEOUT_EN
    // The LAUNCH cycle is the first cycle of the watchdog window, so WAIT_BUSY
    // itself may last TIMEOUT_CYCLES-1 cycles before the frame is abandoned.
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 2);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

    logic [TO_W-1:0] to_cnt_reg;
    logic            timeout;

    // Watchdog counter: cleared in LAUNCH, advances every WAIT_BUSY cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_reg <= '0;
        end else if (state_reg == LAUNCH) begin
            to_cnt_reg <= '0;
        end else if (state_reg == WAIT_BUSY) begin
            to_cnt_reg <= to_cnt_reg + TO_ONE;
        end
    end
`endif

    // Next-state and per-cycle strobes of the frame sequencer
    always_comb begin
        state_next  = state_reg;
        load_status = 1'b0;
        pop         = 1'b0;
        frame_done  = 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
        timeout     = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (status_pend) begin
                    load_status = 1'b1;
                    state_next  = LAUNCH;
                end else if (!fifo_empty && !bus.tx_busy) begin
                    pop        = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end
`ifdef ADC_SCHED_TIMEOUT_EN
                else if (to_cnt_reg == TO_LIMIT) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef ADC_SCHED_TIMEOUT_EN
    assign overflow_set = drop | timeout;
`else
    assign overflow_set = drop;
`endif

    // State register; tx_start is high exactly while the FSM sits in LAUNCH
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            tx_start_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tx_start_reg <= (state_next == LAUNCH);
        end
    end

    // Sample storage: write port only, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.sample_data;
        end
    end

    // FIFO pointers and registered occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_ONE;
                2'b01:   level_reg <= level_reg - LVL_ONE;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Frame register: registered read of the FIFO head or the status word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_data_reg         <= '0;
            frame_is_sample_reg <= 1'b0;
        end else if (load_status) begin
            tx_data_reg         <= {1'b1, drop_cnt_reg};
            frame_is_sample_reg <= 1'b0;
        end else if (pop) begin
            tx_data_reg         <= {1'b0, mem[rd_ptr_reg]};
            frame_is_sample_reg <= 1'b1;
        end
    end

    // Saturating drop counter, restarted whenever a status frame is loaded
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt_reg <= '0;
        end else if (load_status) begin
            drop_cnt_reg <= drop ? DROP_ONE : '0;
        end else if (drop && drop_cnt_reg != DROP_MAX) begin
            drop_cnt_reg <= drop_cnt_reg + DROP_ONE;
        end
    end

    // Sticky overflow flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_reg <= 1'b0;
        end else if (overflow_set) begin
            overflow_reg <= 1'b1;
        end
    end

    generate
        if (STATUS_PERIOD > 0) begin : g_status
            localparam int FC_W = $clog2(STATUS_PERIOD + 1);
            logic [FC_W-1:0] frame_cnt_reg;
            logic            status_pend_reg;

            // Count completed sample frames and request a status frame every STATUS_PERIOD
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    frame_cnt_reg   <= '0;
                    status_pend_reg <= 1'b0;
                end else begin
                    if (load_status) begin
                        status_pend_reg <= 1'b0;
                    end
                    if (frame_done && frame_is_sample_reg) begin
                        if (int'(frame_cnt_reg) + 1 == STATUS_PERIOD) begin
                            frame_cnt_reg   <= '0;
                            status_pend_reg <= 1'b1;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + FC_W'(1);
                        end
                    end
                end
            end

            assign status_pend = status_pend_reg;
        end else begin : g_no_status
            assign status_pend = 1'b0;
        end
    endgenerate

    assign bus.tx_start   = tx_start_reg;
    assign bus.tx_data    = tx_data_reg;
    assign bus.fifo_level = level_reg;
    assign bus.overflow   = overflow_reg;

endmodule

// File: doc/adc_spi_scheduler.md
Name: adc_spi_scheduler

Overview:
- Sits between the sigma-delta ADC core and the 9-bit SPI debug transmitter.
- Buffers ADC samples, qualified by `sample_rdy`, in a small FIFO.
- Interleaves periodic status frames carrying the dropped-sample count.
- Sequences the transmitter with a start/busy handshake, so no sample is lost while a frame is on the wire.

Parameters:
- ADC_WIDTH, 8: sample width; frame width is ADC_WIDTH+1.
- FIFO_DEPTH_BITS, 2: FIFO holds 2^FIFO_DEPTH_BITS samples.
- STATUS_PERIOD, 16: one status frame is inserted after every STATUS_PERIOD sample frames sent; 0 disables status frames.
- TIMEOUT_CYCLES, 15: busy-rise watchdog limit (used only with the optional feature).

Ports:
- clk, in, 1: system clock (PLL output).
- rstn, in, 1: asynchronous active-low reset.
- enable, in, 1: 1 = accept samples; 0 = ignore `sample_rdy`, but already-buffered frames still drain.
- sample_rdy, in, 1: one-cycle pulse from the ADC, sample valid.
- sample_data, in, ADC_WIDTH: ADC result, captured when `sample_rdy`=1.
- tx_busy, in, 1: transmitter busy; high while a frame shifts out.
- tx_start, out, 1: one-cycle pulse launching a frame.
- tx_data, out, ADC_WIDTH+1: frame; MSB 0 = sample, MSB 1 = status.
- fifo_level, out, FIFO_DEPTH_BITS+1: current FIFO occupancy.
- overflow, out, 1: sticky; set on the first dropped sample.

Behaviour:
- Reset (async assert, sync release). All of the following clear to 0:
  - outputs `tx_start`, `tx_data`, `fifo_level`, `overflow`;
  - FIFO pointers, `drop_cnt`, `frame_cnt`;
  - FSM goes to IDLE.
  - Reset mid-frame simply abandons the frame; the transmitter is reset by the same `rstn`.
- FIFO push:
  - `sample_rdy`=1 and `enable`=1 and FIFO not full → write `sample_data`; level +1.
  - FIFO full → sample dropped, `drop_cnt` +1 saturating at 2^ADC_WIDTH-1, `overflow` set.
  - Push and pop in the same cycle while full → push accepted, level unchanged, no drop.
  - Push and pop in the same cycle while empty → not possible; pop requires level≥1 at the start of the cycle.
- FSM states:
  - IDLE:
    - If `status_pend`=1 → load `tx_data`={1'b1,drop_cnt}, clear `drop_cnt` (a same-cycle drop makes it 1, not 0), clear `status_pend` → LAUNCH.
    - Else if FIFO not empty and `tx_busy`=0 → pop the head into `tx_data`={1'b0,sample} → LAUNCH.
    - Otherwise stay in IDLE.
    - Status has priority over samples.
  - LAUNCH: `tx_start`=1 for exactly this cycle → WAIT_BUSY.
  - WAIT_BUSY: stay until `tx_busy`=1 → WAIT_DONE.
  - WAIT_DONE: stay until `tx_busy`=0.
    - If the frame was a sample: `frame_cnt` +1.
    - If `frame_cnt` reaches STATUS_PERIOD: set `status_pend`, clear `frame_cnt`.
    - → IDLE.
- Latency:
  - Sample pushed into an empty FIFO with FSM in IDLE → `tx_start` 2 cycles after the `sample_rdy` cycle (push, IDLE pop, LAUNCH).
  - Minimum inter-frame gap: 2 cycles after `tx_busy` falls.
- `tx_data` holds stable from LAUNCH until the next load in IDLE.
- `fifo_level` is registered and reflects the pointers after this cycle's push/pop.
- `enable` deasserted: pending status frames and buffered samples still drain; only new pushes are blocked.

Optional Feature:
- Macro: ADC_SCHED_TIMEOUT_EN.
- Defined:
  - WAIT_BUSY counts cycles.
  - If `tx_busy` is not seen within TIMEOUT_CYCLES → return to IDLE, the frame is discarded (not retried), and `overflow` is set.
  - The counter clears on entry to WAIT_BUSY.
- Undefined: WAIT_BUSY waits indefinitely; no counter logic is synthesised.

Test Plan:
1. Single sample: reset, `enable`=1, `sample_rdy` with 0xA5, bench transmitter model (busy 1 cycle after start, for 40 cycles) → `tx_start` 2 cycles later, `tx_data`=0x0A5, `fifo_level` returns to 0.
2. Overflow (FIFO_DEPTH_BITS=2): 6 pulses (0x01..0x06) 1 cycle apart during one busy period → 0x01 sent immediately; 0x02–0x05 buffered and sent in order; 0x06 dropped; `overflow`=1.
3. Status insertion (STATUS_PERIOD=4, one earlier drop) → after the 4th sample frame, frame 0x101 is sent; the next status frame carries 0x100.
4. Push/pop collision: FIFO full, `sample_rdy` coinciding with the IDLE pop → no drop, level stays at 4, `overflow` unchanged.
5. Reset mid-frame: assert `rstn`=0 during WAIT_DONE → all outputs 0 immediately; after release, the FSM is in IDLE and the FIFO is empty.
6. Timeout (ADC_SCHED_TIMEOUT_EN defined, TIMEOUT_CYCLES=15): hold `tx_busy`=0 → FSM back to IDLE 15 cycles after LAUNCH, `overflow`=1, the next buffered sample launches.
